// File: rtl/elevator_design.sv
// SCAN elevator controller: latches one floor request per cycle, moves the car one
// floor per clock, holds the door on obstruction/overload and freezes on emergency.
module elevator_design #(
  parameter  int NUM_FLOORS  = 8,
  parameter  int DOOR_CYCLES = 2,
  localparam int FW          = $clog2(NUM_FLOORS),
  localparam int CW          = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [FW-1:0]         req_floor,
  input  logic                  emergency,
  input  logic                  over_weight,
  input  logic                  IR_sensor,
  output logic                  up,
  output logic                  down,
  output logic                  idle,
  output logic                  door,
  output logic [FW-1:0]         max_request,
  output logic [FW-1:0]         min_request,
  output logic                  emergency_stop,
  output logic [FW-1:0]         current_floor,
  output logic [NUM_FLOORS-1:0] requests
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR_OPEN,
    S_EMERGENCY
  } state_e;

  state_e                  state_q, state_d;
  logic [FW-1:0]           floor_q, floor_d;
  logic [NUM_FLOORS-1:0]   req_q, req_d;
  logic                    dir_up_q, dir_up_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    up_q, down_q, idle_q, door_q, estop_q;

  logic [FW-1:0]           max_req, min_req;
  logic [NUM_FLOORS-1:0]   set_vec, clr_vec;
  logic                    at_floor_req, served, pending, above, below;

  // Highest and lowest pending floor; both read 0 when nothing is pending.
  always_comb begin
    max_req = '0;
    min_req = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (req_q[i]) max_req = FW'(i);
    end
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (req_q[i]) min_req = FW'(i);
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    dir_up_d     = dir_up_q;
    cnt_d        = cnt_q;
    set_vec      = '0;
    clr_vec      = '0;
    at_floor_req = (req_floor == floor_q);
    served       = at_floor_req && (state_q == S_IDLE || state_q == S_DOOR_OPEN);
    pending      = |req_q;
    above        = pending && (max_req > floor_q);
    below        = pending && (min_req < floor_q);

    if (!served) set_vec[req_floor] = 1'b1;

    if (emergency) begin
      state_d = S_EMERGENCY;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (at_floor_req) begin
            state_d = S_DOOR_OPEN;
            cnt_d   = '0;
          end else if (above) begin
            state_d  = S_MOVE_UP;
            dir_up_d = 1'b1;
          end else if (below) begin
            state_d  = S_MOVE_DOWN;
            dir_up_d = 1'b0;
          end else if (pending) begin
            // Only the current floor is pending (latched during an emergency): serve it.
            clr_vec[floor_q] = 1'b1;
            state_d          = S_DOOR_OPEN;
            cnt_d            = '0;
          end
        end

        S_MOVE_UP: begin
          if (req_q[floor_q]) begin
            clr_vec[floor_q] = 1'b1;
            state_d          = S_DOOR_OPEN;
            cnt_d            = '0;
          end else if (above) begin
            floor_d = floor_q + 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_MOVE_DOWN: begin
          if (req_q[floor_q]) begin
            clr_vec[floor_q] = 1'b1;
            state_d          = S_DOOR_OPEN;
            cnt_d            = '0;
          end else if (below) begin
            floor_d = floor_q - 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_DOOR_OPEN: begin
          if (over_weight || IR_sensor) begin
            cnt_d = '0;
          end else if (cnt_q == CW'(DOOR_CYCLES - 1)) begin
            // Keep sweeping in the current direction before reversing.
            if (dir_up_q && above) begin
              state_d = S_MOVE_UP;
            end else if (below) begin
              state_d  = S_MOVE_DOWN;
              dir_up_d = 1'b0;
            end else if (above) begin
              state_d  = S_MOVE_UP;
              dir_up_d = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_EMERGENCY: state_d = S_IDLE;

        default: state_d = S_IDLE;
      endcase
    end

    // A clear of a served floor beats a simultaneous re-request of that floor.
    req_d = (req_q | set_vec) & ~clr_vec;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      floor_q  <= '0;
      req_q    <= '0;
      dir_up_q <= 1'b1;
      cnt_q    <= '0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      idle_q   <= 1'b1;
      door_q   <= 1'b0;
      estop_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      req_q    <= req_d;
      dir_up_q <= dir_up_d;
      cnt_q    <= cnt_d;
      up_q     <= (state_d == S_MOVE_UP);
      down_q   <= (state_d == S_MOVE_DOWN);
      idle_q   <= (state_d == S_IDLE);
      door_q   <= (state_d == S_DOOR_OPEN) || (state_d == S_EMERGENCY);
      estop_q  <= (state_d == S_EMERGENCY);
    end
  end

  assign up             = up_q;
  assign down           = down_q;
  assign idle           = idle_q;
  assign door           = door_q;
  assign emergency_stop = estop_q;
  assign current_floor  = floor_q;
  assign requests       = req_q;
  assign max_request    = max_req;
  assign min_request    = min_req;

endmodule

// File: tb/tb_elevator_design.sv
// Self-checking bench for elevator_design: per-cycle expectation table plus
// hand-written emergency and mid-motion reset sequences, checked through a scoreboard.
module tb_elevator_design;

  logic       clock = 1'b0;
  logic       reset, emergency, over_weight, IR_sensor;
  logic [2:0] req_floor;
  logic       up, down, idle, door, emergency_stop;
  logic [2:0] max_request, min_request, current_floor;
  logic [7:0] requests;

  elevator_design #(.NUM_FLOORS(8), .DOOR_CYCLES(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_floor      (req_floor),
    .emergency      (emergency),
    .over_weight    (over_weight),
    .IR_sensor      (IR_sensor),
    .up             (up),
    .down           (down),
    .idle           (idle),
    .door           (door),
    .max_request    (max_request),
    .min_request    (min_request),
    .emergency_stop (emergency_stop),
    .current_floor  (current_floor),
    .requests       (requests)
  );

  always #5 clock = ~clock;

  // Flag order: {up, down, idle, door, emergency_stop}
  localparam logic [4:0] F_IDLE = 5'b00100;
  localparam logic [4:0] F_UP   = 5'b10000;
  localparam logic [4:0] F_DN   = 5'b01000;
  localparam logic [4:0] F_DOOR = 5'b00010;
  localparam logic [4:0] F_EMG  = 5'b00011;

  typedef struct packed {
    logic [4:0] flags;
    logic [2:0] floor;
    logic [7:0] reqs;
    logic [2:0] maxr;
    logic [2:0] minr;
  } obs_t;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       emg;
    logic       ow;
    logic       ir;
    logic [4:0] flags;
    logic [2:0] floor;
    logic [7:0] reqs;
  } vec_t;

  vec_t vecs[$];
  obs_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic obs_t expect_of(input logic [4:0] f, input logic [2:0] fl,
                                     input logic [7:0] r);
    obs_t       o;
    logic [2:0] hi = 3'd0;
    logic [2:0] lo = 3'd0;
    bit         found_hi = 0;
    bit         found_lo = 0;
    for (int i = 7; i >= 0; i--) begin
      if (r[i] && !found_hi) begin hi = 3'(i); found_hi = 1; end
    end
    for (int i = 0; i < 8; i++) begin
      if (r[i] && !found_lo) begin lo = 3'(i); found_lo = 1; end
    end
    o.flags = f;
    o.floor = fl;
    o.reqs  = r;
    o.maxr  = hi;
    o.minr  = lo;
    return o;
  endfunction

  function automatic obs_t observed();
    obs_t o;
    o.flags = {up, down, idle, door, emergency_stop};
    o.floor = current_floor;
    o.reqs  = requests;
    o.maxr  = max_request;
    o.minr  = min_request;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got flags=%b floor=%0d req=%h max=%0d min=%0d, want flags=%b floor=%0d req=%h max=%0d min=%0d",
               name, act.flags, act.floor, act.reqs, act.maxr, act.minr,
               exp.flags, exp.floor, exp.reqs, exp.maxr, exp.minr);
    end
  endtask

  task automatic step(input string name, input logic rst, input logic [2:0] req,
                      input logic emg, input logic ow, input logic ir,
                      input logic [4:0] f, input logic [2:0] fl, input logic [7:0] r);
    reset       = rst;
    req_floor   = req;
    emergency   = emg;
    over_weight = ow;
    IR_sensor   = ir;
    sb.push_back(expect_of(f, fl, r));
    @(posedge clock);
    #1;
    check(name, observed(), sb.pop_front());
  endtask

  task automatic add(input logic rst, input logic [2:0] req, input logic emg,
                     input logic ow, input logic ir, input logic [4:0] f,
                     input logic [2:0] fl, input logic [7:0] r);
    vec_t v;
    v = '{rst: rst, req: req, emg: emg, ow: ow, ir: ir, flags: f, floor: fl, reqs: r};
    vecs.push_back(v);
  endtask

  initial begin
    // Reset, then a held request for floor 6 from floor 0.
    add(1, 6, 0, 0, 0, F_IDLE, 0, 8'h00);
    add(1, 6, 0, 0, 0, F_IDLE, 0, 8'h00);
    add(0, 6, 0, 0, 0, F_IDLE, 0, 8'h40);
    add(0, 6, 0, 0, 0, F_UP,   0, 8'h40);
    for (int k = 1; k <= 6; k++) add(0, 6, 0, 0, 0, F_UP, 3'(k), 8'h40);
    add(0, 6, 0, 0, 0, F_DOOR, 6, 8'h00);
    add(0, 6, 0, 0, 0, F_DOOR, 6, 8'h00);
    add(0, 6, 0, 0, 0, F_IDLE, 6, 8'h00);
    add(0, 6, 0, 0, 0, F_DOOR, 6, 8'h00);

    // Reset while the door is open, then an upward run picking up 5 before 7.
    add(1, 7, 0, 0, 0, F_IDLE, 0, 8'h00);
    add(0, 7, 0, 0, 0, F_IDLE, 0, 8'h80);
    add(0, 7, 0, 0, 0, F_UP,   0, 8'h80);
    add(0, 5, 0, 0, 0, F_UP,   1, 8'hA0);
    for (int k = 2; k <= 5; k++) add(0, 5, 0, 0, 0, F_UP, 3'(k), 8'hA0);
    add(0, 5, 0, 0, 0, F_DOOR, 5, 8'h80);
    add(0, 5, 0, 0, 0, F_DOOR, 5, 8'h80);
    add(0, 5, 0, 0, 0, F_UP,   5, 8'h80);
    add(0, 7, 0, 0, 0, F_UP,   6, 8'h80);
    add(0, 7, 0, 0, 0, F_UP,   7, 8'h80);
    add(0, 7, 0, 0, 0, F_DOOR, 7, 8'h00);
    add(0, 7, 0, 0, 0, F_DOOR, 7, 8'h00);
    add(0, 7, 0, 0, 0, F_IDLE, 7, 8'h00);

    // Idle at 7 with requests for 3 and 1: downward sweep.
    add(0, 3, 0, 0, 0, F_IDLE, 7, 8'h08);
    add(0, 1, 0, 0, 0, F_DN,   7, 8'h0A);
    for (int k = 6; k >= 3; k--) add(0, 1, 0, 0, 0, F_DN, 3'(k), 8'h0A);
    add(0, 1, 0, 0, 0, F_DOOR, 3, 8'h02);
    add(0, 1, 0, 0, 0, F_DOOR, 3, 8'h02);
    add(0, 1, 0, 0, 0, F_DN,   3, 8'h02);
    add(0, 1, 0, 0, 0, F_DN,   2, 8'h02);
    add(0, 1, 0, 0, 0, F_DN,   1, 8'h02);
    add(0, 1, 0, 0, 0, F_DOOR, 1, 8'h00);
    add(0, 1, 0, 0, 0, F_DOOR, 1, 8'h00);
    add(0, 1, 0, 0, 0, F_IDLE, 1, 8'h00);

    // Door held by IR_sensor, then by over_weight, for 5 cycles each.
    add(0, 1, 0, 0, 0, F_DOOR, 1, 8'h00);
    for (int k = 0; k < 5; k++) add(0, 1, 0, 0, 1, F_DOOR, 1, 8'h00);
    add(0, 1, 0, 0, 0, F_DOOR, 1, 8'h00);
    add(0, 1, 0, 0, 0, F_IDLE, 1, 8'h00);
    add(0, 1, 0, 0, 0, F_DOOR, 1, 8'h00);
    for (int k = 0; k < 5; k++) add(0, 1, 0, 1, 0, F_DOOR, 1, 8'h00);
    add(0, 1, 0, 0, 0, F_DOOR, 1, 8'h00);
    add(0, 1, 0, 0, 0, F_IDLE, 1, 8'h00);

    reset = 1'b1; req_floor = 3'd0; emergency = 1'b0; over_weight = 1'b0; IR_sensor = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].emg, vecs[i].ow,
           vecs[i].ir, vecs[i].flags, vecs[i].floor, vecs[i].reqs);
    end

    // Emergency while moving up at floor 3, then resume.
    step("emg_rst",    1, 5, 0, 0, 0, F_IDLE, 0, 8'h00);
    step("emg_latch",  0, 5, 0, 0, 0, F_IDLE, 0, 8'h20);
    step("emg_go",     0, 5, 0, 0, 0, F_UP,   0, 8'h20);
    step("emg_f1",     0, 5, 0, 0, 0, F_UP,   1, 8'h20);
    step("emg_f2",     0, 5, 0, 0, 0, F_UP,   2, 8'h20);
    step("emg_f3",     0, 5, 0, 0, 0, F_UP,   3, 8'h20);
    step("emg_stop",   0, 5, 1, 0, 0, F_EMG,  3, 8'h20);
    step("emg_newreq", 0, 6, 1, 0, 0, F_EMG,  3, 8'h60);
    step("emg_clear",  0, 6, 0, 0, 0, F_IDLE, 3, 8'h60);
    step("emg_resume", 0, 6, 0, 0, 0, F_UP,   3, 8'h60);
    step("emg_f4",     0, 6, 0, 0, 0, F_UP,   4, 8'h60);
    step("emg_f5",     0, 6, 0, 0, 0, F_UP,   5, 8'h60);
    step("emg_door5",  0, 6, 0, 0, 0, F_DOOR, 5, 8'h40);
    step("emg_door5b", 0, 6, 0, 0, 0, F_DOOR, 5, 8'h40);
    step("emg_leave5", 0, 6, 0, 0, 0, F_UP,   5, 8'h40);
    step("emg_f6",     0, 6, 0, 0, 0, F_UP,   6, 8'h40);
    step("emg_door6",  0, 6, 0, 0, 0, F_DOOR, 6, 8'h00);

    // Reset asserted at floor 4 with a request still pending.
    step("mr_rst",     1, 7, 0, 0, 0, F_IDLE, 0, 8'h00);
    step("mr_latch",   0, 7, 0, 0, 0, F_IDLE, 0, 8'h80);
    step("mr_go",      0, 2, 0, 0, 0, F_UP,   0, 8'h84);
    step("mr_f1",      0, 7, 0, 0, 0, F_UP,   1, 8'h84);
    step("mr_f2",      0, 7, 0, 0, 0, F_UP,   2, 8'h84);
    step("mr_door2",   0, 7, 0, 0, 0, F_DOOR, 2, 8'h80);
    step("mr_door2b",  0, 7, 0, 0, 0, F_DOOR, 2, 8'h80);
    step("mr_leave2",  0, 7, 0, 0, 0, F_UP,   2, 8'h80);
    step("mr_f3",      0, 7, 0, 0, 0, F_UP,   3, 8'h80);
    step("mr_f4",      0, 7, 0, 0, 0, F_UP,   4, 8'h80);
    step("mr_reset",   1, 7, 0, 0, 0, F_IDLE, 0, 8'h00);
    step("mr_after",   0, 7, 0, 0, 0, F_IDLE, 0, 8'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
